// File: rtl/neural_interface.sv
// Memory-mapped front end for a 3-layer MLP core: weight/vector access plus FP/BP sequencing.
// Fixed point uses FRAC_BITS fractional bits; all core arithmetic wraps modulo 2**NUM_WIDTH.

module neural_network #(
   parameter int unsigned NUM_WIDTH    = 16,
   parameter int unsigned INPUT_SIZE   = 8,
   parameter int unsigned HIDDEN1_SIZE = 8,
   parameter int unsigned HIDDEN2_SIZE = 8,
   parameter int unsigned OUTPUT_SIZE  = 8,
   parameter int unsigned FRAC_BITS    = 8
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  w_we,
   input  logic [1:0]                            w_layer,
   input  logic [9:0]                            w_row,
   input  logic [9:0]                            w_col,
   input  logic [NUM_WIDTH-1:0]                  w_wdata,
   output logic [NUM_WIDTH-1:0]                  w_rdata,
   input  logic [INPUT_SIZE-1:0][NUM_WIDTH-1:0]  a0,
   input  logic [OUTPUT_SIZE-1:0][NUM_WIDTH-1:0] g3,
   input  logic                                  update,
   output logic [OUTPUT_SIZE-1:0][NUM_WIDTH-1:0] a3
);

   localparam int unsigned PW = 2 * NUM_WIDTH;

   logic [NUM_WIDTH-1:0] w01 [INPUT_SIZE][HIDDEN1_SIZE];
   logic [NUM_WIDTH-1:0] w12 [HIDDEN1_SIZE][HIDDEN2_SIZE];
   logic [NUM_WIDTH-1:0] w23 [HIDDEN2_SIZE][OUTPUT_SIZE];
   logic [NUM_WIDTH-1:0] a1 [HIDDEN1_SIZE];
   logic [NUM_WIDTH-1:0] a2 [HIDDEN2_SIZE];
   logic [NUM_WIDTH-1:0] g1 [HIDDEN1_SIZE];
   logic [NUM_WIDTH-1:0] g2 [HIDDEN2_SIZE];

   // Low PW bits of the product of sign-extended operands equal the signed product.
   function automatic logic [PW-1:0] mul(input logic [NUM_WIDTH-1:0] x,
                                         input logic [NUM_WIDTH-1:0] y);
      return {{NUM_WIDTH{x[NUM_WIDTH-1]}}, x} * {{NUM_WIDTH{y[NUM_WIDTH-1]}}, y};
   endfunction

   function automatic logic [NUM_WIDTH-1:0] fix(input logic [PW-1:0] p);
      return p[FRAC_BITS+NUM_WIDTH-1:FRAC_BITS];
   endfunction

   always_comb begin
      logic [PW-1:0] acc;
      acc = '0;
      for (int j = 0; j < HIDDEN1_SIZE; j++) begin
         acc = '0;
         for (int i = 0; i < INPUT_SIZE; i++) acc = acc + mul(a0[i], w01[i][j]);
         a1[j] = fix(acc);
      end
   end

   always_comb begin
      logic [PW-1:0] acc;
      acc = '0;
      for (int j = 0; j < HIDDEN2_SIZE; j++) begin
         acc = '0;
         for (int i = 0; i < HIDDEN1_SIZE; i++) acc = acc + mul(a1[i], w12[i][j]);
         a2[j] = fix(acc);
      end
   end

   always_comb begin
      logic [PW-1:0] acc;
      acc = '0;
      for (int j = 0; j < OUTPUT_SIZE; j++) begin
         acc = '0;
         for (int i = 0; i < HIDDEN2_SIZE; i++) acc = acc + mul(a2[i], w23[i][j]);
         a3[j] = fix(acc);
      end
   end

   // Gradients propagate backwards through the transposed weight matrices.
   always_comb begin
      logic [PW-1:0] acc;
      acc = '0;
      for (int i = 0; i < HIDDEN2_SIZE; i++) begin
         acc = '0;
         for (int j = 0; j < OUTPUT_SIZE; j++) acc = acc + mul(w23[i][j], g3[j]);
         g2[i] = fix(acc);
      end
   end

   always_comb begin
      logic [PW-1:0] acc;
      acc = '0;
      for (int i = 0; i < HIDDEN1_SIZE; i++) begin
         acc = '0;
         for (int j = 0; j < HIDDEN2_SIZE; j++) acc = acc + mul(w12[i][j], g2[j]);
         g1[i] = fix(acc);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < INPUT_SIZE; i++)
            for (int j = 0; j < HIDDEN1_SIZE; j++) w01[i][j] <= '0;
         for (int i = 0; i < HIDDEN1_SIZE; i++)
            for (int j = 0; j < HIDDEN2_SIZE; j++) w12[i][j] <= '0;
         for (int i = 0; i < HIDDEN2_SIZE; i++)
            for (int j = 0; j < OUTPUT_SIZE; j++) w23[i][j] <= '0;
      end else begin
         // A register write to a weight takes priority over the training update.
         for (int i = 0; i < INPUT_SIZE; i++)
            for (int j = 0; j < HIDDEN1_SIZE; j++)
               if (w_we && w_layer == 2'd0 && w_row == 10'(i) && w_col == 10'(j))
                  w01[i][j] <= w_wdata;
               else if (update)
                  w01[i][j] <= w01[i][j] + fix(mul(a0[i], g1[j]));
         for (int i = 0; i < HIDDEN1_SIZE; i++)
            for (int j = 0; j < HIDDEN2_SIZE; j++)
               if (w_we && w_layer == 2'd1 && w_row == 10'(i) && w_col == 10'(j))
                  w12[i][j] <= w_wdata;
               else if (update)
                  w12[i][j] <= w12[i][j] + fix(mul(a1[i], g2[j]));
         for (int i = 0; i < HIDDEN2_SIZE; i++)
            for (int j = 0; j < OUTPUT_SIZE; j++)
               if (w_we && w_layer == 2'd2 && w_row == 10'(i) && w_col == 10'(j))
                  w23[i][j] <= w_wdata;
               else if (update)
                  w23[i][j] <= w23[i][j] + fix(mul(a2[i], g3[j]));
      end
   end

   always_comb begin
      w_rdata = '0;
      for (int i = 0; i < INPUT_SIZE; i++)
         for (int j = 0; j < HIDDEN1_SIZE; j++)
            if (w_layer == 2'd0 && w_row == 10'(i) && w_col == 10'(j)) w_rdata = w01[i][j];
      for (int i = 0; i < HIDDEN1_SIZE; i++)
         for (int j = 0; j < HIDDEN2_SIZE; j++)
            if (w_layer == 2'd1 && w_row == 10'(i) && w_col == 10'(j)) w_rdata = w12[i][j];
      for (int i = 0; i < HIDDEN2_SIZE; i++)
         for (int j = 0; j < OUTPUT_SIZE; j++)
            if (w_layer == 2'd2 && w_row == 10'(i) && w_col == 10'(j)) w_rdata = w23[i][j];
   end

endmodule

module neural_interface #(
   parameter int unsigned NUM_WIDTH    = 16,
   parameter int unsigned INPUT_SIZE   = 8,
   parameter int unsigned HIDDEN1_SIZE = 8,
   parameter int unsigned HIDDEN2_SIZE = 8,
   parameter int unsigned OUTPUT_SIZE  = 8,
   parameter int unsigned FP_LATENCY   = 4,
   parameter int unsigned BP_LATENCY   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [23:0]          addr,
   input  logic [NUM_WIDTH-1:0] data_in,
   input  logic                 we,
   output logic [NUM_WIDTH-1:0] data_out
);

   localparam int unsigned MaxLat = (FP_LATENCY > BP_LATENCY) ? FP_LATENCY : BP_LATENCY;
   localparam int unsigned CntW   = $clog2(MaxLat + 1);
   localparam logic [CntW-1:0] FpLast = CntW'(FP_LATENCY - 1);
   localparam logic [CntW-1:0] BpLast = CntW'(BP_LATENCY - 1);

   typedef enum logic {StIdle, StRun} run_e;

   logic [3:0] region;
   logic [9:0] row, col;
   logic       w_hit, in_a0, in_g3, in_a3, is_ctl, fp_wr, bp_wr;

   logic [INPUT_SIZE-1:0][NUM_WIDTH-1:0]  a0_q;
   logic [OUTPUT_SIZE-1:0][NUM_WIDTH-1:0] g3_q, a3_q, nn_a3;
   logic [NUM_WIDTH-1:0] nn_rdata, rd_data;

   run_e            fp_state, bp_state;
   logic [CntW-1:0] fp_cnt, bp_cnt;
   logic            fp_en, bp_en, fp_hold, bp_hold;
   logic            fp_done, bp_step, bp_fire;

   assign region = addr[23:20];
   assign row    = addr[19:10];
   assign col    = addr[9:0];

   assign w_hit = (region == 4'd0 && row < 10'(INPUT_SIZE)   && col < 10'(HIDDEN1_SIZE)) ||
                  (region == 4'd1 && row < 10'(HIDDEN1_SIZE) && col < 10'(HIDDEN2_SIZE)) ||
                  (region == 4'd2 && row < 10'(HIDDEN2_SIZE) && col < 10'(OUTPUT_SIZE));
   assign in_a0  = region == 4'd4 && row == '0 && col < 10'(INPUT_SIZE);
   assign in_g3  = region == 4'd5 && row == '0 && col < 10'(OUTPUT_SIZE);
   assign in_a3  = region == 4'd6 && row == '0 && col < 10'(OUTPUT_SIZE);
   assign is_ctl = region == 4'd7;
   assign fp_wr  = we && is_ctl && col == 10'd0;
   assign bp_wr  = we && is_ctl && col == 10'd1;

   // BP counting is frozen while an FP run is in flight.
   assign fp_done = fp_state == StRun && fp_cnt == FpLast;
   assign bp_step = bp_state == StRun && fp_state != StRun;
   assign bp_fire = bp_step && bp_cnt == BpLast;

   neural_network #(
      .NUM_WIDTH   (NUM_WIDTH),
      .INPUT_SIZE  (INPUT_SIZE),
      .HIDDEN1_SIZE(HIDDEN1_SIZE),
      .HIDDEN2_SIZE(HIDDEN2_SIZE),
      .OUTPUT_SIZE (OUTPUT_SIZE),
      .FRAC_BITS   (8)
   ) i_nn (
      .clk    (clk),
      .rst_n  (rst_n),
      .w_we   (we && w_hit),
      .w_layer(region[1:0]),
      .w_row  (row),
      .w_col  (col),
      .w_wdata(data_in),
      .w_rdata(nn_rdata),
      .a0     (a0_q),
      .g3     (g3_q),
      .update (bp_fire),
      .a3     (nn_a3)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a0_q <= '0;
         g3_q <= '0;
         a3_q <= '0;
      end else begin
         for (int j = 0; j < INPUT_SIZE; j++)
            if (we && in_a0 && col == 10'(j)) a0_q[j] <= data_in;
         for (int j = 0; j < OUTPUT_SIZE; j++) begin
            if (we && in_g3 && col == 10'(j)) g3_q[j] <= data_in;
            if (we && in_a3 && col == 10'(j)) a3_q[j] <= data_in;
            else if (fp_done)                 a3_q[j] <= nn_a3[j];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fp_state <= StIdle;
         bp_state <= StIdle;
         fp_cnt   <= '0;
         bp_cnt   <= '0;
         fp_en    <= 1'b0;
         bp_en    <= 1'b0;
         fp_hold  <= 1'b0;
         bp_hold  <= 1'b0;
      end else begin
         if (fp_done) begin
            fp_state <= StIdle;
            fp_cnt   <= '0;
            fp_hold  <= 1'b1;
         end else if (fp_state == StRun) begin
            fp_cnt <= fp_cnt + CntW'(1);
         end
         if (bp_fire) begin
            bp_state <= StIdle;
            bp_cnt   <= '0;
            bp_hold  <= 1'b1;
         end else if (bp_step) begin
            bp_cnt <= bp_cnt + CntW'(1);
         end
         // Only a 0->1 edge of the enable starts a run; clearing it aborts.
         if (fp_wr) begin
            fp_en <= data_in[0];
            if (data_in[0] && !fp_en) begin
               fp_state <= StRun;
               fp_cnt   <= '0;
               fp_hold  <= 1'b0;
            end else if (!data_in[0]) begin
               fp_state <= StIdle;
               fp_cnt   <= '0;
            end
         end
         if (bp_wr) begin
            bp_en <= data_in[0];
            if (data_in[0] && !bp_en) begin
               bp_state <= StRun;
               bp_cnt   <= '0;
               bp_hold  <= 1'b0;
            end else if (!data_in[0]) begin
               bp_state <= StIdle;
               bp_cnt   <= '0;
            end
         end
      end
   end

   always_comb begin
      rd_data = '0;
      if (w_hit) rd_data = nn_rdata;
      for (int j = 0; j < INPUT_SIZE; j++)
         if (in_a0 && col == 10'(j)) rd_data = a0_q[j];
      for (int j = 0; j < OUTPUT_SIZE; j++) begin
         if (in_g3 && col == 10'(j)) rd_data = g3_q[j];
         if (in_a3 && col == 10'(j)) rd_data = a3_q[j];
      end
      if (is_ctl) begin
         case (col)
            10'd0:   rd_data = {{(NUM_WIDTH-1){1'b0}}, fp_en};
            10'd1:   rd_data = {{(NUM_WIDTH-1){1'b0}}, bp_en};
            10'd2:   rd_data = {{(NUM_WIDTH-1){1'b0}}, fp_hold};
            10'd3:   rd_data = {{(NUM_WIDTH-1){1'b0}}, bp_hold};
            default: rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_out <= '0;
      else        data_out <= rd_data;
   end

endmodule

// File: tb/tb_neural_interface.sv
// Bench for neural_interface: directed scenarios then random register traffic, all checked
// against an array-based model of the MLP and its FP/BP sequencing.

module tb_neural_interface;

   localparam int N   = 8;
   localparam int FPL = 4;
   localparam int BPL = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] addr = '0;
   logic [15:0] data_in = '0;
   logic        we = 1'b0;
   logic [15:0] data_out;

   always #5 clk = ~clk;

   neural_interface #(
      .NUM_WIDTH(16), .INPUT_SIZE(N), .HIDDEN1_SIZE(N), .HIDDEN2_SIZE(N), .OUTPUT_SIZE(N),
      .FP_LATENCY(FPL), .BP_LATENCY(BPL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .we(we), .data_out(data_out)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
      end
   endtask

   // Reference state: signed weights/vectors as plain ints, runs as cycles-remaining counts.
   int mw [3][N][N];
   int ma0 [N], mg3 [N], ma3 [N];
   int f1 [N], f2 [N], f3 [N], b1 [N], b2 [N];
   bit m_fp_en, m_bp_en, m_fp_hold, m_bp_hold;
   int fp_left, bp_left;

   function automatic int s16(input longint v);
      logic [15:0] t;
      t = v[15:0];
      return int'($signed(t));
   endfunction

   function automatic int fx(input longint s);
      return s16(s >>> 8);
   endfunction

   function automatic void model_reset();
      for (int l = 0; l < 3; l++)
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) mw[l][i][j] = 0;
      for (int j = 0; j < N; j++) begin
         ma0[j] = 0; mg3[j] = 0; ma3[j] = 0;
      end
      m_fp_en = 0; m_bp_en = 0; m_fp_hold = 0; m_bp_hold = 0;
      fp_left = 0; bp_left = 0;
   endfunction

   function automatic void compute();
      longint s;
      for (int j = 0; j < N; j++) begin
         s = 0;
         for (int i = 0; i < N; i++) s += longint'(ma0[i]) * mw[0][i][j];
         f1[j] = fx(s);
      end
      for (int j = 0; j < N; j++) begin
         s = 0;
         for (int i = 0; i < N; i++) s += longint'(f1[i]) * mw[1][i][j];
         f2[j] = fx(s);
      end
      for (int j = 0; j < N; j++) begin
         s = 0;
         for (int i = 0; i < N; i++) s += longint'(f2[i]) * mw[2][i][j];
         f3[j] = fx(s);
      end
      for (int i = 0; i < N; i++) begin
         s = 0;
         for (int j = 0; j < N; j++) s += longint'(mw[2][i][j]) * mg3[j];
         b2[i] = fx(s);
      end
      for (int i = 0; i < N; i++) begin
         s = 0;
         for (int j = 0; j < N; j++) s += longint'(mw[1][i][j]) * b2[j];
         b1[i] = fx(s);
      end
   endfunction

   function automatic int model_read(input logic [23:0] a);
      int rg, r, c;
      rg = int'(a[23:20]);
      r  = int'(a[19:10]);
      c  = int'(a[9:0]);
      if (rg <= 2) return (r < N && c < N) ? mw[rg][r][c] : 0;
      if (rg == 4 && r == 0 && c < N) return ma0[c];
      if (rg == 5 && r == 0 && c < N) return mg3[c];
      if (rg == 6 && r == 0 && c < N) return ma3[c];
      if (rg == 7) begin
         if (c == 0) return int'(m_fp_en);
         if (c == 1) return int'(m_bp_en);
         if (c == 2) return int'(m_fp_hold);
         if (c == 3) return int'(m_bp_hold);
      end
      return 0;
   endfunction

   function automatic void model_edge(input logic [23:0] a, input logic [15:0] d, input bit w);
      int rg, r, c, dv;
      bit fp_busy_before;
      rg = int'(a[23:20]);
      r  = int'(a[19:10]);
      c  = int'(a[9:0]);
      dv = int'($signed(d));
      compute();
      fp_busy_before = fp_left > 0;
      if (fp_left == 1) begin
         for (int j = 0; j < N; j++) ma3[j] = f3[j];
         m_fp_hold = 1;
         fp_left = 0;
      end else if (fp_left > 0) fp_left--;
      if (bp_left == 1 && !fp_busy_before) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               mw[0][i][j] = s16(mw[0][i][j] + fx(longint'(ma0[i]) * b1[j]));
               mw[1][i][j] = s16(mw[1][i][j] + fx(longint'(f1[i]) * b2[j]));
               mw[2][i][j] = s16(mw[2][i][j] + fx(longint'(f2[i]) * mg3[j]));
            end
         m_bp_hold = 1;
         bp_left = 0;
      end else if (bp_left > 0 && !fp_busy_before) bp_left--;
      if (!w) return;
      if (rg <= 2 && r < N && c < N) mw[rg][r][c] = dv;
      if (rg == 4 && r == 0 && c < N) ma0[c] = dv;
      if (rg == 5 && r == 0 && c < N) mg3[c] = dv;
      if (rg == 6 && r == 0 && c < N) ma3[c] = dv;
      if (rg == 7 && c == 0) begin
         if (d[0] && !m_fp_en) begin fp_left = FPL; m_fp_hold = 0; end
         else if (!d[0]) fp_left = 0;
         m_fp_en = d[0];
      end
      if (rg == 7 && c == 1) begin
         if (d[0] && !m_bp_en) begin bp_left = BPL; m_bp_hold = 0; end
         else if (!d[0]) bp_left = 0;
         m_bp_en = d[0];
      end
   endfunction

   function automatic logic [23:0] mk(input int rg, input int r, input int c);
      return {rg[3:0], r[9:0], c[9:0]};
   endfunction

   // One clock: present the access, step the model, then check the registered read.
   task automatic op(input string tag, input logic [23:0] a, input logic [15:0] d, input bit w);
      logic [15:0] exp;
      addr    = a;
      data_in = d;
      we      = w;
      exp     = 16'(model_read(a));
      model_edge(a, d, w);
      @(posedge clk);
      #1;
      we = 1'b0;
      check(tag, data_out, exp);
   endtask

   initial begin
      int k, rg, r, c;
      bit w;
      logic [23:0] a;
      logic [15:0] d;

      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_dout", data_out, 16'h0000);
      rst_n = 1'b1;

      op("rd_w01_00",   mk(0, 0, 0), 16'd0, 0);
      op("wr_w23_73",   mk(2, 7, 3), 16'd15, 1);
      op("rd_w23_73",   mk(2, 7, 3), 16'd0, 0);
      op("rd_w23_73_b", mk(2, 7, 3), 16'd0, 0);
      op("rd_w01_00_b", mk(0, 0, 0), 16'd0, 0);

      op("wr_a0_5", mk(4, 0, 5), 16'd33, 1);
      op("rd_a0_5", mk(4, 0, 5), 16'd0, 0);
      op("wr_g3_5", mk(5, 0, 5), 16'd17, 1);
      op("rd_g3_5", mk(5, 0, 5), 16'd0, 0);
      op("wr_a3_5", mk(6, 0, 5), 16'd9, 1);
      op("rd_a3_5", mk(6, 0, 5), 16'd0, 0);
      op("wr_oor",  mk(4, 0, 1023), 16'd77, 1);
      op("rd_oor",  mk(4, 0, 1023), 16'd0, 0);
      op("wr_row1", mk(4, 1, 2), 16'd5, 1);
      op("rd_row1", mk(4, 0, 2), 16'd0, 0);

      op("fp_start", mk(7, 0, 0), 16'd1, 1);
      for (int i = 0; i < FPL + 2; i++) op("fp_hold_poll", mk(7, 0, 2), 16'd0, 0);
      for (int j = 0; j < N; j++) op("fp_a3", mk(6, 0, j), 16'd0, 0);
      op("fp_clear_en", mk(7, 0, 0), 16'd0, 1);
      op("fp_hold_sticky", mk(7, 0, 2), 16'd0, 0);

      op("bp_w01", mk(0, 1, 2), 16'd256, 1);
      op("bp_w12", mk(1, 2, 3), 16'd256, 1);
      op("bp_w23", mk(2, 3, 5), 16'd256, 1);
      op("bp_a0",  mk(4, 0, 1), 16'd256, 1);
      op("bp_g3",  mk(5, 0, 5), 16'd256, 1);
      op("bp_start", mk(7, 0, 1), 16'd1, 1);
      for (int i = 0; i < BPL + 2; i++) begin
         op("bp_hold_poll", mk(7, 0, 3), 16'd0, 0);
         op("bp_w23_35", mk(2, 3, 5), 16'd0, 0);
      end
      for (int i = 0; i < 3; i++) begin
         op("bp_once_w01", mk(0, 1, 5), 16'd0, 0);
         op("bp_once_w12", mk(1, 2, 3), 16'd0, 0);
         op("bp_once_w23", mk(2, 7, 5), 16'd0, 0);
      end

      op("ab_a3", mk(6, 0, 2), 16'd99, 1);
      op("ab_start", mk(7, 0, 0), 16'd1, 1);
      op("ab_idle", mk(7, 0, 2), 16'd0, 0);
      op("ab_idle", mk(7, 0, 2), 16'd0, 0);
      op("ab_stop", mk(7, 0, 0), 16'd0, 1);
      for (int i = 0; i < FPL + 2; i++) begin
         op("ab_hold", mk(7, 0, 2), 16'd0, 0);
         op("ab_a3_2", mk(6, 0, 2), 16'd0, 0);
      end

      op("rbp_stop",  mk(7, 0, 1), 16'd0, 1);
      op("rbp_start", mk(7, 0, 1), 16'd1, 1);
      op("rbp_run",   mk(7, 0, 1), 16'd0, 0);
      op("rbp_run",   mk(2, 3, 5), 16'd0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rbp_async_dout", data_out, 16'h0000);
      model_reset();
      @(posedge clk);
      #1;
      check("rbp_held_dout", data_out, 16'h0000);
      rst_n = 1'b1;
      for (int i = 0; i < BPL + 2; i++) begin
         op("rbp_bp_en", mk(7, 0, 1), 16'd0, 0);
         op("rbp_bp_hold", mk(7, 0, 3), 16'd0, 0);
         op("rbp_w23", mk(2, 3, 5), 16'd0, 0);
      end

      for (int n = 0; n < 2500; n++) begin
         k = $urandom_range(0, 9);
         w = bit'($urandom_range(0, 1));
         d = 16'($urandom_range(0, 1023) - 512);
         rg = 0; r = 0; c = 0;
         case (k)
            0, 1, 2, 8: begin
               rg = (k == 8) ? $urandom_range(0, 2) : k;
               r  = $urandom_range(0, N);
               c  = $urandom_range(0, N);
            end
            3, 4, 5: begin
               rg = 4 + (k - 3);
               r  = ($urandom_range(0, 7) == 0) ? 1 : 0;
               c  = $urandom_range(0, N);
            end
            6, 7: begin
               rg = 7;
               c  = $urandom_range(0, 4);
               w  = ($urandom_range(0, 3) == 0);
            end
            default: ;
         endcase
         a = (k == 9) ? 24'($urandom) : mk(rg, r, c);
         op("rand", a, d, w);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
